triangle_rasterizer: RTL and testbench

- Consumes the per-edge equations produced by the vertex/edge setup stage, plus the raw screen-space vertices.
- Scans the triangle's screen-clamped bounding box in raster order, evaluates the three edge functions incrementally, and emits one fragment (x,y) per covered pixel over a valid/ready stream.
- Sits between triangle setup and the fragment/pixel-write stage.

---
 rtl/triangle_rasterizer_if.sv | 26 ++
 rtl/triangle_rasterizer.sv | 167 ++++++++++++++++
 tb/tb_triangle_rasterizer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/triangle_rasterizer_if.sv
// Setup-to-rasterizer command bus and rasterizer-to-fragment stream.
// The slave modport is the rasterizer's view.
interface triangle_rasterizer_if #(
   parameter int unsigned COORD_WIDTH = 16
);
   logic                                   start;
   logic [2:0][2:0][COORD_WIDTH-1:0]       vertexes;
   logic [2:0][1:0][COORD_WIDTH-1:0]       bound_coefs;
   logic [2:0][2*COORD_WIDTH-1:0]          bound_const;
   logic                                   busy;
   logic                                   frag_valid;
   logic                                   frag_ready;
   logic [COORD_WIDTH-1:0]                 frag_x;
   logic [COORD_WIDTH-1:0]                 frag_y;
   logic                                   done;

   modport master (
      output start, vertexes, bound_coefs, bound_const, frag_ready,
      input  busy, frag_valid, frag_x, frag_y, done
   );

   modport slave (
      input  start, vertexes, bound_coefs, bound_const, frag_ready,
      output busy, frag_valid, frag_x, frag_y, done
   );
endinterface

// File: rtl/triangle_rasterizer.sv
// Scans a triangle's screen-clamped bounding box in raster order and emits one
// fragment per covered pixel, stepping the three edge functions incrementally.
module triangle_rasterizer #(
   parameter int unsigned COORD_WIDTH   = 16,
   parameter int unsigned SCREEN_X_SIZE = 800,
   parameter int unsigned SCREEN_Y_SIZE = 600
) (
   input logic                  clk,
   input logic                  reset_n,
   triangle_rasterizer_if.slave rast_io
);
   localparam int unsigned CW   = COORD_WIDTH;
   localparam int unsigned AccW = 2 * CW + 4;

   typedef logic [CW-1:0]          coord_t;
   typedef logic signed [AccW-1:0] acc_t;
   typedef enum logic [2:0] {StIdle, StSetup, StInit, StScan, StDone} state_e;

   localparam coord_t XLast = coord_t'(SCREEN_X_SIZE - 1);
   localparam coord_t YLast = coord_t'(SCREEN_Y_SIZE - 1);
   localparam coord_t One   = coord_t'(1);

   function automatic acc_t sext_coef(input coord_t v);
      return {{(AccW-CW){v[CW-1]}}, v};
   endfunction

   function automatic acc_t zext_coord(input coord_t v);
      return {{(AccW-CW){1'b0}}, v};
   endfunction

   function automatic acc_t sext_const(input logic [2*CW-1:0] v);
      return {{(AccW-2*CW){v[2*CW-1]}}, v};
   endfunction

   state_e            state_q;
   logic              busy_q, done_q, area_pos_q;
   coord_t            vx_q [3];
   coord_t            vy_q [3];
   coord_t            a_q  [3];
   coord_t            b_q  [3];
   logic [2*CW-1:0]   c_q  [3];
   coord_t            xmin_q, xmax_q, ymin_q, ymax_q, x_q, y_q;
   acc_t              row_e_q [3];
   acc_t              cur_e_q [3];

   coord_t            xmin_c, xmax_c, ymin_c, ymax_c;
   acc_t              area_c;
   acc_t              e_init_c [3];
   logic              all_ge_c, all_le_c, inside_c;

   always_comb begin
      xmin_c = vx_q[0];
      xmax_c = vx_q[0];
      ymin_c = vy_q[0];
      ymax_c = vy_q[0];
      for (int i = 1; i < 3; i++) begin
         if (vx_q[i] < xmin_c) xmin_c = vx_q[i];
         if (vx_q[i] > xmax_c) xmax_c = vx_q[i];
         if (vy_q[i] < ymin_c) ymin_c = vy_q[i];
         if (vy_q[i] > ymax_c) ymax_c = vy_q[i];
      end
      area_c = sext_const(c_q[0]) + sext_const(c_q[1]) + sext_const(c_q[2]);
      all_ge_c = 1'b1;
      all_le_c = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e_init_c[i] = sext_coef(a_q[i]) * zext_coord(xmin_q) +
                       sext_coef(b_q[i]) * zext_coord(ymin_q) + sext_const(c_q[i]);
         all_ge_c &= !cur_e_q[i][AccW-1];
         all_le_c &= cur_e_q[i][AccW-1] || (cur_e_q[i] == '0);
      end
      // Winding decides which side of the edges counts as inside.
      inside_c = area_pos_q ? all_ge_c : all_le_c;
   end

   assign rast_io.frag_valid = (state_q == StScan) && inside_c;
   assign rast_io.frag_x     = x_q;
   assign rast_io.frag_y     = y_q;
   assign rast_io.busy       = busy_q;
   assign rast_io.done       = done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         area_pos_q <= 1'b0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymin_q     <= '0;
         ymax_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         for (int i = 0; i < 3; i++) begin
            vx_q[i]    <= '0;
            vy_q[i]    <= '0;
            a_q[i]     <= '0;
            b_q[i]     <= '0;
            c_q[i]     <= '0;
            row_e_q[i] <= '0;
            cur_e_q[i] <= '0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rast_io.start) begin
                  for (int i = 0; i < 3; i++) begin
                     vx_q[i] <= rast_io.vertexes[i][0];
                     vy_q[i] <= rast_io.vertexes[i][1];
                     a_q[i]  <= rast_io.bound_coefs[i][0];
                     b_q[i]  <= rast_io.bound_coefs[i][1];
                     c_q[i]  <= rast_io.bound_const[i];
                  end
                  busy_q  <= 1'b1;
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               xmin_q     <= xmin_c;
               ymin_q     <= ymin_c;
               xmax_q     <= (xmax_c > XLast) ? XLast : xmax_c;
               ymax_q     <= (ymax_c > YLast) ? YLast : ymax_c;
               area_pos_q <= !area_c[AccW-1];
               if (area_c == '0 || xmin_c > XLast || ymin_c > YLast) begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  state_q <= StInit;
               end
            end
            StInit: begin
               for (int i = 0; i < 3; i++) begin
                  row_e_q[i] <= e_init_c[i];
                  cur_e_q[i] <= e_init_c[i];
               end
               x_q     <= xmin_q;
               y_q     <= ymin_q;
               state_q <= StScan;
            end
            StScan: begin
               // Uncovered pixels never wait on the consumer.
               if (!inside_c || rast_io.frag_ready) begin
                  if (x_q < xmax_q) begin
                     x_q <= x_q + One;
                     for (int i = 0; i < 3; i++) cur_e_q[i] <= cur_e_q[i] + sext_coef(a_q[i]);
                  end else if (y_q < ymax_q) begin
                     x_q <= xmin_q;
                     y_q <= y_q + One;
                     for (int i = 0; i < 3; i++) begin
                        row_e_q[i] <= row_e_q[i] + sext_coef(b_q[i]);
                        cur_e_q[i] <= row_e_q[i] + sext_coef(b_q[i]);
                     end
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Scoreboard bench: a direct edge-function model queues expected fragments
// per triangle; accepted fragments are popped and compared in order.
module tb_triangle_rasterizer;
   localparam int unsigned CW = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   triangle_rasterizer_if #(.COORD_WIDTH(CW)) tif ();

   triangle_rasterizer #(
      .COORD_WIDTH  (CW),
      .SCREEN_X_SIZE(800),
      .SCREEN_Y_SIZE(600)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .rast_io(tif)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q [$];
   int          vx [3];
   int          vy [3];
   int          ca [3];
   int          cb [3];
   int          cc [3];
   bit          saw_799_0;
   int          max_x;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic load_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2);
      vx = '{x0, x1, x2};
      vy = '{y0, y1, y2};
      for (int i = 0; i < 3; i++) begin
         int j;
         j = (i + 1) % 3;
         ca[i] = vy[i] - vy[j];
         cb[i] = vx[j] - vx[i];
         cc[i] = vx[i] * vy[j] - vx[j] * vy[i];
         tif.vertexes[i][0]    = 16'(vx[i]);
         tif.vertexes[i][1]    = 16'(vy[i]);
         tif.vertexes[i][2]    = 16'(i);
         tif.bound_coefs[i][0] = 16'(ca[i]);
         tif.bound_coefs[i][1] = 16'(cb[i]);
         tif.bound_const[i]    = 32'(cc[i]);
      end
   endtask

   // Direct evaluation of every bounding-box pixel; pushes covered ones.
   task automatic model(output int n_exp, output int n_bbox);
      int xmin, xmax, ymin, ymax;
      longint area, e0, e1, e2;
      bit in;
      n_exp  = 0;
      n_bbox = 0;
      xmin = vx[0]; xmax = vx[0]; ymin = vy[0]; ymax = vy[0];
      for (int i = 1; i < 3; i++) begin
         if (vx[i] < xmin) xmin = vx[i];
         if (vx[i] > xmax) xmax = vx[i];
         if (vy[i] < ymin) ymin = vy[i];
         if (vy[i] > ymax) ymax = vy[i];
      end
      if (xmax > 799) xmax = 799;
      if (ymax > 599) ymax = 599;
      area = longint'(cc[0]) + longint'(cc[1]) + longint'(cc[2]);
      if (area == 0 || xmin > 799 || ymin > 599) return;
      n_bbox = (xmax - xmin + 1) * (ymax - ymin + 1);
      for (int y = ymin; y <= ymax; y++) begin
         for (int x = xmin; x <= xmax; x++) begin
            e0 = longint'(ca[0]) * x + longint'(cb[0]) * y + cc[0];
            e1 = longint'(ca[1]) * x + longint'(cb[1]) * y + cc[1];
            e2 = longint'(ca[2]) * x + longint'(cb[2]) * y + cc[2];
            in = (area > 0) ? (e0 >= 0 && e1 >= 0 && e2 >= 0) : (e0 <= 0 && e1 <= 0 && e2 <= 0);
            if (in) begin
               exp_q.push_back({16'(x), 16'(y)});
               n_exp++;
            end
         end
      end
   endtask

   // mode 0: ready held high, 1: random ready, 2: stall the first fragment 3 cycles.
   task automatic run_tri(input int mode, input bit inject, input string name);
      int n_exp, n_bbox, exp_done, cyc, n_got, stall_cnt;
      bit seen_done, stalled, first;
      logic [15:0] px, py;
      logic [31:0] e;
      model(n_exp, n_bbox);
      exp_done = (n_bbox == 0) ? 2 : 3 + n_bbox + ((mode == 2) ? 3 : 0);
      n_got = 0; stall_cnt = 0; seen_done = 0; stalled = 0; first = 1;
      px = '0; py = '0;
      @(negedge clk);
      tif.start      = 1'b1;
      tif.frag_ready = 1'b1;
      @(negedge clk);
      tif.start       = 1'b0;
      tif.vertexes    = '0;
      tif.bound_coefs = '0;
      tif.bound_const = '0;
      check_eq({name, "_busy"}, tif.busy, 1);
      cyc = 1;
      while (!seen_done && cyc < 5000) begin
         if (stalled) begin
            check_eq({name, "_hold_valid"}, tif.frag_valid, 1);
            check_eq({name, "_hold_xy"}, {tif.frag_x, tif.frag_y}, {px, py});
         end
         if (tif.done) begin
            seen_done = 1;
            check_eq({name, "_valid_at_done"}, tif.frag_valid, 0);
            if (mode != 1) check_eq({name, "_done_cycle"}, cyc, exp_done);
         end else begin
            if (mode == 1) tif.frag_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) tif.frag_ready = !(tif.frag_valid && stall_cnt < 3);
            if (mode == 2 && tif.frag_valid && !tif.frag_ready) stall_cnt++;
            if (tif.frag_valid && first) begin
               first = 0;
               if (mode == 0) check_eq({name, "_first_valid"}, cyc, 3);
            end
            if (inject) tif.start = (cyc == 5);
            if (tif.frag_valid && tif.frag_ready) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
               check_eq({name, "_frag_xy"}, {tif.frag_x, tif.frag_y}, e);
               if (tif.frag_x == 16'd799 && tif.frag_y == 16'd0) saw_799_0 = 1;
               if (int'(tif.frag_x) > max_x) max_x = int'(tif.frag_x);
               n_got++;
            end
            stalled = tif.frag_valid && !tif.frag_ready;
            px = tif.frag_x;
            py = tif.frag_y;
            @(negedge clk);
            cyc++;
         end
      end
      tif.start = 1'b0;
      check_eq({name, "_done_seen"}, seen_done, 1);
      check_eq({name, "_frag_count"}, n_got, n_exp);
      check_eq({name, "_leftover"}, exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      check_eq({name, "_done_pulse"}, tif.done, 0);
      check_eq({name, "_busy_after"}, tif.busy, 0);
   endtask

   initial begin
      bit done_seen;
      tif.start       = 1'b0;
      tif.frag_ready  = 1'b0;
      tif.vertexes    = '0;
      tif.bound_coefs = '0;
      tif.bound_const = '0;
      #12;
      check_eq("rst_busy", tif.busy, 0);
      check_eq("rst_valid", tif.frag_valid, 0);
      check_eq("rst_done", tif.done, 0);
      check_eq("rst_xy", {tif.frag_x, tif.frag_y}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      load_tri(0, 0, 4, 0, 0, 4);
      run_tri(0, 0, "tri");
      load_tri(0, 0, 0, 4, 4, 0);
      run_tri(0, 0, "tri_rev");
      load_tri(0, 0, 2, 2, 4, 4);
      run_tri(0, 0, "degen");
      load_tri(0, 0, 4, 0, 0, 4);
      run_tri(2, 0, "bp");
      load_tri(0, 0, 4, 0, 0, 4);
      run_tri(1, 1, "rand");

      saw_799_0 = 0;
      max_x = 0;
      load_tri(790, 0, 1000, 0, 790, 10);
      run_tri(0, 0, "clamp");
      check_eq("clamp_col799", saw_799_0, 1);
      check_eq("clamp_max_x", max_x, 799);
      load_tri(900, 0, 950, 0, 900, 50);
      run_tri(0, 0, "offscreen");

      // Abort mid-scan with an asynchronous reset.
      load_tri(0, 0, 4, 0, 0, 4);
      @(negedge clk);
      tif.start      = 1'b1;
      tif.frag_ready = 1'b1;
      @(negedge clk);
      tif.start = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("pre_rst_busy", tif.busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", tif.busy, 0);
      check_eq("mid_rst_valid", tif.frag_valid, 0);
      check_eq("mid_rst_done", tif.done, 0);
      check_eq("mid_rst_xy", {tif.frag_x, tif.frag_y}, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (tif.done || tif.frag_valid || tif.busy) done_seen = 1;
      end
      check_eq("post_rst_quiet", done_seen, 0);
      load_tri(0, 0, 4, 0, 0, 4);
      run_tri(0, 0, "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
